// File: rtl/frq_period_meter.sv
// frq_period_meter: measures period and high time of an asynchronous input
// in local clk cycles, flags lock on stable periods and timeout on no edges.
module frq_period_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 65535,
  parameter int unsigned MIN_STABLE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [3:0]       MS_VAL = 4'(MIN_STABLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cap;
  logic [3:0]       match_cnt, match_nxt;
  logic             have_prev;
  logic             near;

  // Decoded actions for the current cycle
  logic cnt_clr, cnt_one, do_cap, do_to, hi_ld, lock_clr;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // New period within +/-1 of the last reported one (synchronizer jitter)
  always_comb begin
    logic [CNT_W:0] cnt_x, per_x;
    cnt_x = {1'b0, cnt};
    per_x = {1'b0, period};
    near  = (cnt_x == per_x) || (cnt_x == per_x + 1'b1) || (per_x == cnt_x + 1'b1);
    match_nxt = '0;
    if (have_prev && near)
      match_nxt = (match_cnt >= MS_VAL) ? MS_VAL : match_cnt + 4'd1;
  end

  // Next-state and action decode; en=0 overrides everything and forces IDLE
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_one   = 1'b0;
    do_cap    = 1'b0;
    do_to     = 1'b0;
    hi_ld     = 1'b0;
    lock_clr  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr  = 1'b1;
        lock_clr = 1'b1;
        if (en) state_nxt = ARM;
      end
      ARM: begin
        if (rise) begin
          cnt_one   = 1'b1;
          state_nxt = MEAS;
        end else if (cnt == TO_VAL) begin
          do_to   = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      MEAS: begin
        // rise takes priority over a coincident timeout
        if (rise) begin
          do_cap  = 1'b1;
          cnt_one = 1'b1;
        end else if (cnt == TO_VAL) begin
          do_to     = 1'b1;
          lock_clr  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ARM;
        end
        if (fall && !rise) hi_ld = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
      cnt_one   = 1'b0;
      do_cap    = 1'b0;
      do_to     = 1'b0;
      hi_ld     = 1'b0;
      lock_clr  = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Rise-to-rise counter, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           cnt <= '0;
    else if (cnt_clr)       cnt <= '0;
    else if (cnt_one)       cnt <= CNT_W'(1);
    else if (cnt != '1)     cnt <= cnt + 1'b1;
  end

  // Measurement capture, timeout flag and lock tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period    <= '0;
      high_time <= '0;
      hi_cap    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
      match_cnt <= '0;
      have_prev <= 1'b0;
    end else begin
      valid <= do_cap;
      if (hi_ld) hi_cap <= cnt;
      if (do_cap) begin
        period    <= cnt;
        high_time <= hi_cap;
        timeout   <= 1'b0;
      end else if (do_to) begin
        timeout <= 1'b1;
      end
      // first capture after entering MEAS has no reference period
      if (do_cap)                have_prev <= 1'b1;
      else if (state_nxt != MEAS) have_prev <= 1'b0;
      if (lock_clr) begin
        match_cnt <= '0;
        locked    <= 1'b0;
      end else if (do_cap) begin
        match_cnt <= match_nxt;
        locked    <= (match_nxt >= MS_VAL);
      end
    end
  end

endmodule

// File: tb/tb_frq_period_meter.sv
// Testbench for frq_period_meter: table-driven wave sequence plus directed
// timeout, enable, corner-period and mid-stream reset sequences.
module tb_frq_period_meter;

  logic        clk;
  logic        reset_n;
  logic        sig_in;
  logic        en;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        valid;
  logic        locked;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;
  int gap_err = 0;
  logic prev_v = 1'b0;

  typedef struct {
    int   p;
    int   h;
    int   exp_p;
    int   exp_h;
    logic exp_l;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    logic [15:0] h;
    logic        l;
    logic        t;
  } cap_t;

  vec_t tbl[13];
  cap_t q[$];

  frq_period_meter #(
    .CNT_W(16),
    .TIMEOUT(1000),
    .MIN_STABLE(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sig_in(sig_in),
    .en(en),
    .period(period),
    .high_time(high_time),
    .valid(valid),
    .locked(locked),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every valid pulse and flag back-to-back pulses
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      if (prev_v === 1'b1) gap_err++;
      q.push_back('{period, high_time, locked, timeout});
      vcnt++;
    end
    prev_v = valid;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  // One input cycle starting at a negedge: h cycles high, p-h cycles low
  task automatic wave(input int p, input int h);
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  initial begin
    int vb;
    cap_t c;

    tbl[0]  = '{10, 4, 10, 4, 1'b0};
    tbl[1]  = '{10, 4, 10, 4, 1'b0};
    tbl[2]  = '{10, 4, 10, 4, 1'b1};
    tbl[3]  = '{10, 4, 10, 4, 1'b1};
    tbl[4]  = '{11, 5, 11, 5, 1'b1};
    tbl[5]  = '{10, 4, 10, 4, 1'b1};
    tbl[6]  = '{11, 5, 11, 5, 1'b1};
    tbl[7]  = '{24, 12, 24, 12, 1'b0};
    tbl[8]  = '{24, 12, 24, 12, 1'b0};
    tbl[9]  = '{24, 12, 24, 12, 1'b1};
    tbl[10] = '{10, 4, 10, 4, 1'b0};
    tbl[11] = '{10, 4, 10, 4, 1'b0};
    tbl[12] = '{10, 4, 10, 4, 1'b1};

    reset_n = 1'b1;
    en      = 1'b0;
    sig_in  = 1'b0;
    #3 reset_n = 1'b0;
    #2 chk_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven steady / jitter / change sequence
    for (int unsigned i = 0; i < 13; i++) wave(tbl[i].p, tbl[i].h);

    // Final rise, then hold high until timeout
    sig_in = 1'b1;
    for (int k = 1; k <= 1003; k++) begin
      @(negedge clk);
      if (k == 2)    chk("latency_before", valid, 0);
      if (k == 3)    chk("latency_valid", valid, 1);
      if (k == 1002) chk("timeout_early", timeout, 0);
    end
    chk("timeout_set", timeout, 1);
    chk("timeout_unlock", locked, 0);
    chk("timeout_period_hold", period, 10);
    chk("timeout_high_hold", high_time, 4);

    chk("table_count", q.size(), 13);
    for (int unsigned i = 0; i < 13; i++) begin
      if (i < q.size()) begin
        c = q[i];
        chk($sformatf("tbl%0d_period", i), c.p, tbl[i].exp_p);
        chk($sformatf("tbl%0d_high", i), c.h, tbl[i].exp_h);
        chk($sformatf("tbl%0d_locked", i), c.l, tbl[i].exp_l);
      end
    end

    // Restart after timeout: first valid on second rise, timeout cleared
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    vb = vcnt;
    wave(10, 4);
    chk("restart_first_rise_no_valid", vcnt, vb);
    wave(10, 4);
    chk("restart_second_rise_valid", vcnt, vb + 1);
    chk("restart_period", period, 10);
    chk("restart_timeout_clr", timeout, 0);
    chk("restart_locked", locked, 0);

    repeat (3) wave(10, 4);
    chk("relock", locked, 1);

    // Drop en mid-period
    sig_in = 1'b1;
    repeat (4) @(negedge clk);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_disable_locked", locked, 1);
    vb = vcnt;
    en = 1'b0;
    @(negedge clk);
    chk("disable_unlock", locked, 0);
    repeat (3) @(negedge clk);
    repeat (3) wave(10, 4);
    chk("disable_no_valid", vcnt, vb);
    chk("disable_period_hold", period, 10);
    chk("disable_locked", locked, 0);
    en = 1'b1;
    wave(10, 4);
    chk("reenable_first_rise_no_valid", vcnt, vb);
    wave(10, 4);
    chk("reenable_second_rise_valid", vcnt, vb + 1);
    chk("reenable_locked", locked, 0);
    chk("reenable_period", period, 10);

    // Period exactly TIMEOUT: rise wins
    wave(10, 4);
    wave(1000, 4);
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("corner_valid", valid, 1);
    chk("corner_period", period, 1000);
    chk("corner_no_timeout", timeout, 0);
    vb = vcnt;
    @(negedge clk);
    sig_in = 1'b0;
    repeat (997) @(negedge clk);
    // Period TIMEOUT+1: counter expires first
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("over_timeout_set", timeout, 1);
    chk("over_no_valid", vcnt, vb);
    chk("over_period_hold", period, 1000);

    // Asynchronous reset mid-measurement
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    wave(10, 4);
    wave(10, 4);
    sig_in = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("midreset");
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vb = vcnt;
    wave(10, 4);
    chk("postreset_first_rise_no_valid", vcnt, vb);
    wave(10, 4);
    chk("postreset_second_rise_valid", vcnt, vb + 1);
    chk("postreset_period", period, 10);
    chk("postreset_high", high_time, 4);

    chk("no_back_to_back_valid", gap_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
